obf_seq_ctrl: RTL

Instruction-substitution sequencer for the OR1200 on-chip obfuscator. It sits between the instruction fetch stream and the decode stage, downstream of the opcode index generator. It takes each fetched instruction together with its obfuscation index and looks up a per-index descriptor. It then either passes the instruction through unchanged or replaces it with a multi-word sequence read from an external substitution ROM, under valid/ready flow control on both sides.

---
 rtl/obf_seq_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/obf_seq_ctrl.sv
// Instruction-substitution sequencer: passes fetched instructions through or
// replaces them with a multi-word sequence read from an external substitution ROM.
module obf_seq_ctrl #(
    parameter int OBF_INDEX_WIDTH = 7,
    parameter int SEQ_ADDR_WIDTH  = 9,
    parameter int SEQ_LEN_WIDTH   = 3
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      en,
    input  logic                                      cfg_we,
    input  logic [OBF_INDEX_WIDTH-1:0]                cfg_idx,
    input  logic [SEQ_ADDR_WIDTH+SEQ_LEN_WIDTH:0]     cfg_data,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [31:0]                               in_insn,
    input  logic [OBF_INDEX_WIDTH-1:0]                in_idx,
    output logic                                      rom_rd,
    output logic [SEQ_ADDR_WIDTH-1:0]                 rom_addr,
    input  logic [31:0]                               rom_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [31:0]                               out_insn,
    output logic                                      out_last,
    output logic                                      out_subst,
    output logic [15:0]                               subst_cnt,
    input  logic                                      cnt_clr
);

    localparam int DW    = 1 + SEQ_ADDR_WIDTH + SEQ_LEN_WIDTH;
    localparam int NDESC = 1 << OBF_INDEX_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PASS,
        S_RD,
        S_EMIT
    } state_t;

    state_t                      state, state_nx;
    logic [DW-1:0]               desc [NDESC];
    logic [DW-1:0]               desc_rd;
    logic                        rd_en;
    logic [SEQ_ADDR_WIDTH-1:0]   rd_base;
    logic [SEQ_LEN_WIDTH-1:0]    rd_lenm1;
    logic [31:0]                 insn_q;
    logic [SEQ_ADDR_WIDTH-1:0]   base_q;
    logic [SEQ_LEN_WIDTH-1:0]    lenm1_q;
    logic [SEQ_LEN_WIDTH-1:0]    cnt, cnt_inc;
    logic                        accept, go_subst, last, advance;

    // Table read is the registered (pre-write) contents, so a same-cycle cfg_we
    // to the accepted index does not affect the acceptance decision.
    assign desc_rd                      = desc[in_idx];
    assign {rd_en, rd_base, rd_lenm1}   = desc_rd;

    assign accept   = in_valid && (state == S_IDLE);
    assign go_subst = en && rd_en && (in_idx != '1);
    assign last     = (cnt == lenm1_q);
    assign advance  = (state == S_EMIT) && out_ready && !last;
    assign cnt_inc  = cnt + SEQ_LEN_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NDESC; i++) begin
                desc[i] <= '0;
            end
        end else if (cfg_we) begin
            desc[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            insn_q    <= '0;
            base_q    <= '0;
            lenm1_q   <= '0;
            cnt       <= '0;
            subst_cnt <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                insn_q  <= in_insn;
                base_q  <= rd_base;
                lenm1_q <= rd_lenm1;
                cnt     <= '0;
            end else if (advance) begin
                cnt <= cnt_inc;
            end
            if (cnt_clr) begin
                subst_cnt <= '0;
            end else if (accept && go_subst && (subst_cnt != '1)) begin
                subst_cnt <= subst_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_insn  = '0;
        out_last  = 1'b0;
        out_subst = 1'b0;
        rom_rd    = 1'b0;
        // Address wraps naturally modulo 2^SEQ_ADDR_WIDTH.
        rom_addr  = base_q + SEQ_ADDR_WIDTH'(cnt_inc);
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = go_subst ? S_RD : S_PASS;
                end
            end
            S_PASS: begin
                out_valid = 1'b1;
                out_insn  = insn_q;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            S_RD: begin
                rom_rd   = 1'b1;
                rom_addr = base_q;
                state_nx = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_insn  = rom_data;
                out_subst = 1'b1;
                out_last  = last;
                rom_rd    = advance;
                if (out_ready && last) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
